// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: control FSM for a 2-way set-associative, write-back,
// write-allocate cache. It sequences the data, tag/valid/dirty and LRU arrays
// and moves whole lines over the physical memory port.
//
// Handshakes: the CPU holds mem_read/mem_write until the controller returns a
// one-cycle mem_resp. The controller holds pmem_read/pmem_write until
// pmem_resp. pmem_resp is only consumed in WRITEBACK and ALLOCATE.
module cache_ctrl_2way #(
    parameter int s_offset = 5,
    parameter int s_count  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [3:0]               mem_byte_enable,
    input  logic [s_offset-3:0]      word_offset,
    output logic                     mem_resp,
    input  logic                     hit0,
    input  logic                     hit1,
    input  logic                     valid0,
    input  logic                     valid1,
    input  logic                     dirty0,
    input  logic                     dirty1,
    input  logic                     lru_out,
    output logic                     pmem_read,
    output logic                     pmem_write,
    input  logic                     pmem_resp,
    output logic                     array_read,
    output logic [2**s_offset-1:0]   data_we0,
    output logic [2**s_offset-1:0]   data_we1,
    output logic                     data_in_sel,
    output logic                     pmem_addr_sel,
    output logic                     way_sel,
    output logic [1:0]               load_tag,
    output logic [1:0]               load_valid,
    output logic [1:0]               load_dirty,
    output logic                     dirty_in,
    output logic                     load_lru,
    output logic                     lru_in,
    output logic [s_count-1:0]       hit_count,
    output logic [s_count-1:0]       miss_count,
    output logic [2:0]               state_dbg
);

    localparam int LB = 2**s_offset;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        REFILL    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic          victim_q;     // way chosen for replacement, stable until next COMPARE
    logic          write_q;      // current request is a write (write wins over read)
    logic          refill_q;     // this COMPARE follows a refill; its hit is not counted
    logic          hit_any;
    logic          hit_way;
    logic          victim_dirty;
    logic [LB-1:0] word_mask;

    assign hit_any      = hit0 | hit1;
    assign hit_way      = ~hit0 & hit1;
    assign victim_dirty = lru_out ? (valid1 & dirty1) : (valid0 & dirty0);
    assign word_mask    = {{(LB-4){1'b0}}, mem_byte_enable} << {word_offset, 2'b00};
    assign state_dbg    = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (mem_read || mem_write) state_d = COMPARE;
            COMPARE: begin
                if (hit_any)           state_d = IDLE;
                else if (victim_dirty) state_d = WRITEBACK;
                else                   state_d = ALLOCATE;
            end
            WRITEBACK: if (pmem_resp) state_d = ALLOCATE;
            ALLOCATE:  if (pmem_resp) state_d = REFILL;
            REFILL:    state_d = COMPARE;
            default:   state_d = IDLE;
        endcase
    end

    // Per-transaction context: request kind, victim way and refill marker
    always_ff @(posedge clk) begin
        if (!rst) begin
            victim_q <= 1'b0;
            write_q  <= 1'b0;
            refill_q <= 1'b0;
        end else begin
            if (state_q == IDLE && (mem_read || mem_write)) write_q <= mem_write;
            if (state_q == COMPARE && !hit_any)             victim_q <= lru_out;
            if (state_q == REFILL)                          refill_q <= 1'b1;
            else if (state_q == COMPARE)                    refill_q <= 1'b0;
        end
    end

    // Saturating hit/miss performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == COMPARE) begin
            if (hit_any) begin
                if (!refill_q && hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end

    // Output decode; everything is held idle while reset is asserted
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        array_read    = 1'b0;
        data_we0      = '0;
        data_we1      = '0;
        data_in_sel   = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        load_tag      = 2'b00;
        load_valid    = 2'b00;
        load_dirty    = 2'b00;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) array_read = 1'b1;
                end
                COMPARE: begin
                    if (hit_any) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (write_q) begin
                            if (hit_way) data_we1 = word_mask;
                            else         data_we0 = word_mask;
                            load_dirty[hit_way] = 1'b1;
                            dirty_in            = 1'b1;
                        end
                    end else begin
                        way_sel = lru_out;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = victim_q;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        if (victim_q) data_we1 = '1;
                        else          data_we0 = '1;
                        data_in_sel          = 1'b1;
                        load_tag[victim_q]   = 1'b1;
                        load_valid[victim_q] = 1'b1;
                        load_dirty[victim_q] = 1'b1;
                        dirty_in             = 1'b0;
                    end
                end
                REFILL: begin
                    array_read = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb_cache_ctrl_2way: directed and random transactions against cache_ctrl_2way
// with a scoreboard of expected response values.
module tb_cache_ctrl_2way;

  localparam int SO = 5;
  localparam int SC = 4;
  localparam int LB = 2**SO;
  localparam int CNT_MAX = 2**SC - 1;

  logic            clk;
  logic            rst;
  logic            mem_read, mem_write;
  logic [3:0]      mem_byte_enable;
  logic [SO-3:0]   word_offset;
  logic            mem_resp;
  logic            hit0, hit1, valid0, valid1, dirty0, dirty1, lru_out;
  logic            pmem_read, pmem_write, pmem_resp;
  logic            array_read;
  logic [LB-1:0]   data_we0, data_we1;
  logic            data_in_sel, pmem_addr_sel, way_sel;
  logic [1:0]      load_tag, load_valid, load_dirty;
  logic            dirty_in, load_lru, lru_in;
  logic [SC-1:0]   hit_count, miss_count;
  logic [2:0]      state_dbg;

  cache_ctrl_2way #(.s_offset(SO), .s_count(SC)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .word_offset(word_offset),
    .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .lru_out(lru_out),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .array_read(array_read), .data_we0(data_we0), .data_we1(data_we1),
    .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
    .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty),
    .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int model_hits   = 0;
  int model_misses = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0h expected <scoreboard empty>", tag, got);
    end else begin
      check_val(tag, got, exp_q.pop_front());
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  // One CPU transaction; on a miss the bench plays pmem with latency lat
  task automatic run_txn(input bit rd, input bit wr, input bit [2:0] woff, input bit [3:0] be,
                         input bit h0, input bit h1, input bit v0, input bit v1,
                         input bit d0, input bit d1, input bit lru, input int lat);
    bit          hit;
    bit          way;
    bit          dmiss;
    logic [31:0] mask;
    hit   = h0 | h1;
    way   = hit ? !h0 : lru;
    dmiss = lru ? (v1 & d1) : (v0 & d0);
    mask  = 32'(be) << (int'(woff) * 4);
    if (!wr) mask = 32'h0;
    if (hit) model_hits = sat_inc(model_hits);
    else     model_misses = sat_inc(model_misses);
    // expected response, in pop order
    exp_q.push_back(way ? 32'h0 : mask);
    exp_q.push_back(way ? mask : 32'h0);
    exp_q.push_back(wr ? (way ? 32'd2 : 32'd1) : 32'd0);
    exp_q.push_back(32'(wr));
    exp_q.push_back(32'(way));
    exp_q.push_back(32'(!way));
    exp_q.push_back(32'(model_hits));
    exp_q.push_back(32'(model_misses));

    mem_read = rd; mem_write = wr; mem_byte_enable = be; word_offset = woff;
    hit0 = h0; hit1 = h1; valid0 = v0; valid1 = v1; dirty0 = d0; dirty1 = d1; lru_out = lru;
    #1;
    check_val("idle_array_read", array_read, 1);
    check_val("idle_mem_resp", mem_resp, 0);
    @(negedge clk); #1;
    if (!hit) begin
      check_val("miss_mem_resp", mem_resp, 0);
      check_val("miss_way_sel", way_sel, lru);
      if (dmiss) begin
        for (int c = 1; c <= lat; c++) begin
          @(negedge clk);
          pmem_resp = (c == lat);
          #1;
          check_val("wb_pmem_write", pmem_write, 1);
          check_val("wb_pmem_read", pmem_read, 0);
          check_val("wb_addr_sel", pmem_addr_sel, 1);
          check_val("wb_way_sel", way_sel, lru);
          check_val("wb_data_we", data_we0 | data_we1, 0);
        end
      end
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        pmem_resp = (c == lat);
        #1;
        check_val("alloc_pmem_read", pmem_read, 1);
        check_val("alloc_pmem_write", pmem_write, 0);
        check_val("alloc_addr_sel", pmem_addr_sel, 0);
        if (c == lat) begin
          check_val("alloc_we0", data_we0, lru ? 32'h0 : 32'hFFFF_FFFF);
          check_val("alloc_we1", data_we1, lru ? 32'hFFFF_FFFF : 32'h0);
          check_val("alloc_in_sel", data_in_sel, 1);
          check_val("alloc_load_tag", load_tag, lru ? 2 : 1);
          check_val("alloc_load_valid", load_valid, lru ? 2 : 1);
          check_val("alloc_load_dirty", load_dirty, lru ? 2 : 1);
          check_val("alloc_dirty_in", dirty_in, 0);
        end else begin
          check_val("alloc_we_idle", data_we0 | data_we1, 0);
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      hit0 = !lru; hit1 = lru;
      #1;
      check_val("refill_array_read", array_read, 1);
      check_val("refill_pmem", {pmem_read, pmem_write}, 0);
      @(negedge clk); #1;
    end
    check_val("resp_mem_resp", mem_resp, 1);
    check_val("resp_load_lru", load_lru, 1);
    pop_check("resp_we0", data_we0);
    pop_check("resp_we1", data_we1);
    pop_check("resp_load_dirty", load_dirty);
    pop_check("resp_dirty_in", dirty_in);
    pop_check("resp_way_sel", way_sel);
    pop_check("resp_lru_in", lru_in);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    #1;
    pop_check("hit_count", hit_count);
    pop_check("miss_count", miss_count);
    check_val("back_to_idle", state_dbg, 0);
  endtask

  initial begin
    rst = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable = 4'h0; word_offset = '0;
    hit0 = 1'b1; hit1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0;
    lru_out = 1'b0; pmem_resp = 1'b1;

    // reset held for two cycles with live-looking inputs
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("rst_mem_resp", mem_resp, 0);
    check_val("rst_array_read", array_read, 0);
    check_val("rst_pmem", {pmem_read, pmem_write}, 0);
    check_val("rst_we", data_we0 | data_we1, 0);
    check_val("rst_load_lru", load_lru, 0);
    mem_read = 1'b0; hit0 = 1'b0; pmem_resp = 1'b0; rst = 1'b1;
    #1;
    check_val("rst_hit_count", hit_count, 0);
    check_val("rst_miss_count", miss_count, 0);
    check_val("rst_state", state_dbg, 0);

    // read hit way 0
    run_txn(1, 0, 3'd0, 4'h0, 1, 0, 1, 1, 0, 0, 0, 1);
    // write hit way 1, word 3, bytes 0110 -> data_we1 = 0000_6000
    run_txn(0, 1, 3'd3, 4'b0110, 0, 1, 1, 1, 0, 0, 0, 1);
    // both ways hit: way 0 selected
    run_txn(1, 0, 3'd1, 4'h0, 1, 1, 1, 1, 0, 0, 1, 1);
    // read miss, victim way 0 valid+dirty, pmem latency 5
    run_txn(1, 0, 3'd2, 4'h0, 0, 0, 1, 1, 1, 0, 0, 5);
    // clean write miss into way 1, pmem latency 3
    run_txn(0, 1, 3'd7, 4'b1001, 0, 0, 1, 1, 0, 0, 1, 3);
    // read and write together count as a write
    run_txn(1, 1, 3'd5, 4'b1111, 0, 1, 1, 1, 0, 0, 0, 1);
    // dirty miss on way 1, single-cycle pmem
    run_txn(0, 1, 3'd0, 4'b0001, 0, 0, 1, 1, 0, 1, 1, 1);

    // random hits, enough to drive hit_count into saturation
    for (int i = 0; i < 14; i++) begin
      bit rw, h0r, h1r;
      bit [2:0] wo;
      bit [3:0] bev;
      rw  = 1'($urandom_range(0, 1));
      wo  = 3'($urandom_range(0, 7));
      bev = 4'($urandom_range(1, 15));
      h0r = 1'($urandom_range(0, 1));
      h1r = h0r ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(!rw, rw, wo, bev, h0r, h1r, 1, 1, 0, 0, 1'($urandom_range(0, 1)), 1);
    end
    check_val("hit_saturated", hit_count, CNT_MAX);

    // reset in the middle of ALLOCATE
    mem_read = 1'b1; lru_out = 1'b1; valid1 = 1'b0; dirty1 = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    @(negedge clk); #1;
    check_val("mid_miss_way_sel", way_sel, 1);
    @(negedge clk); #1;
    check_val("mid_alloc_pmem_read", pmem_read, 1);
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b1;
    #1;
    check_val("mid_rst_we", data_we0 | data_we1, 0);
    check_val("mid_rst_load_tag", load_tag, 0);
    @(negedge clk);
    rst = 1'b1; pmem_resp = 1'b0; mem_read = 1'b0;
    #1;
    check_val("mid_rst_pmem_read", pmem_read, 0);
    check_val("mid_rst_state", state_dbg, 0);
    check_val("mid_rst_hits", hit_count, 0);
    check_val("mid_rst_misses", miss_count, 0);
    model_hits = 0; model_misses = 0;

    // recovery: one read hit on way 1
    run_txn(1, 0, 3'd4, 4'h0, 0, 1, 1, 1, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
